// File: rtl/axi_mon_pkg.sv
// Shared constants for the AXI B-channel response monitor.
// Response codes and the counter slot assigned to each response.
package axi_mon_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int IDX_OKAY   = 0;
    localparam int IDX_EXOKAY = 1;
    localparam int IDX_SLVERR = 2;
    localparam int IDX_DECERR = 3;
    localparam int NUM_RESP   = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/axi_bresp_monitor.sv
// AXI write-response monitor: response counters, outstanding tracking,
// first-error capture, timeout and accounting-fault flags.
module axi_bresp_monitor
    import axi_mon_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int ID_W    = 4,
    parameter int OST_W   = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               aw_valid,
    input  logic               aw_ready,
    input  logic               b_valid,
    input  logic [1:0]         b_resp,
    input  logic [ID_W-1:0]    b_id,
    output logic               b_ready,
    input  logic               clr,
    input  logic               snap,
    output logic [4*CNT_W-1:0] cnt_out,
    output logic [OST_W-1:0]   outstanding,
    output logic               err_valid,
    output logic [1:0]         err_resp,
    output logic [ID_W-1:0]    err_id,
    output logic               underflow,
    output logic               overflow,
    output logic               timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [OST_W-1:0] OST_MAX = {OST_W{1'b1}};

    logic               r_b_ready;
    logic [4*CNT_W-1:0] r_snap;
    logic [OST_W-1:0]   r_ost;
    logic               r_err_valid;
    logic [1:0]         r_err_resp;
    logic [ID_W-1:0]    r_err_id;
    logic               r_underflow;
    logic               r_overflow;
    logic               r_timeout;
    logic [IDLE_W-1:0]  r_idle;

    logic               w_aw_hs;
    logic               w_b_hs;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    logic               w_qual;
    logic [CNT_W-1:0]   w_cnt [NUM_RESP];

    assign w_aw_hs   = aw_valid & aw_ready;
    assign w_b_hs    = b_valid & r_b_ready;
    assign w_ovf_evt = w_aw_hs & ~w_b_hs & (r_ost == OST_MAX);
    assign w_unf_evt = w_b_hs & ~w_aw_hs & (r_ost == '0);
    assign w_qual    = (r_ost != '0) & ~w_b_hs;

    for (genvar g = 0; g < NUM_RESP; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (w_b_hs && (b_resp == 2'(g))),
            .clr   (clr),
            .count (w_cnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_ready <= 1'b0;
        end else begin
            r_b_ready <= 1'b1;
        end
    end

    // Snapshot samples pre-update values and deliberately ignores clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (snap) begin
            r_snap <= {w_cnt[IDX_DECERR], w_cnt[IDX_SLVERR],
                       w_cnt[IDX_EXOKAY], w_cnt[IDX_OKAY]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ost <= '0;
        end else if (w_aw_hs && !w_b_hs) begin
            if (r_ost != OST_MAX) begin
                r_ost <= r_ost + 1'b1;
            end
        end else if (w_b_hs && !w_aw_hs) begin
            if (r_ost != '0) begin
                r_ost <= r_ost - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_err_valid <= 1'b0;
            r_err_resp  <= '0;
            r_err_id    <= '0;
        end else if (w_b_hs && b_resp[1] && !r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_resp  <= b_resp;
            r_err_id    <= b_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Idle counter parks at TIMEOUT so the flag is set exactly once.
    always_ff @(posedge clk) begin
        if (rst || clr || !w_qual) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_W'(TIMEOUT)) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_timeout <= 1'b0;
        end else if (w_qual && (r_idle == IDLE_W'(TIMEOUT - 1))) begin
            r_timeout <= 1'b1;
        end
    end

    assign b_ready     = r_b_ready;
    assign cnt_out     = r_snap;
    assign outstanding = r_ost;
    assign err_valid   = r_err_valid;
    assign err_resp    = r_err_resp;
    assign err_id      = r_err_id;
    assign underflow   = r_underflow;
    assign overflow    = r_overflow;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_axi_bresp_monitor.sv
// Directed self-checking bench for axi_bresp_monitor.
// Two instances: 8-bit counters and 4-bit counters, both TIMEOUT=16.
module tb_axi_bresp_monitor;

    logic        clk;
    logic        rst;
    logic        aw_valid;
    logic        aw_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        clr;
    logic        snap;

    logic        b_ready;
    logic [31:0] cnt_out;
    logic [5:0]  outstanding;
    logic        err_valid;
    logic [1:0]  err_resp;
    logic [3:0]  err_id;
    logic        underflow;
    logic        overflow;
    logic        timeout;

    logic        b_ready4;
    logic [15:0] cnt_out4;
    logic [5:0]  outstanding4;
    logic        err_valid4;
    logic [1:0]  err_resp4;
    logic [3:0]  err_id4;
    logic        underflow4;
    logic        overflow4;
    logic        timeout4;

    int checks;
    int errors;

    axi_bresp_monitor #(
        .CNT_W(8), .ID_W(4), .OST_W(6), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_id(b_id),
        .b_ready(b_ready), .clr(clr), .snap(snap),
        .cnt_out(cnt_out), .outstanding(outstanding),
        .err_valid(err_valid), .err_resp(err_resp), .err_id(err_id),
        .underflow(underflow), .overflow(overflow), .timeout(timeout)
    );

    axi_bresp_monitor #(
        .CNT_W(4), .ID_W(4), .OST_W(6), .TIMEOUT(16)
    ) dut4 (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_id(b_id),
        .b_ready(b_ready4), .clr(clr), .snap(snap),
        .cnt_out(cnt_out4), .outstanding(outstanding4),
        .err_valid(err_valid4), .err_resp(err_resp4), .err_id(err_id4),
        .underflow(underflow4), .overflow(overflow4), .timeout(timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_beat();
        aw_valid = 1'b1;
        aw_ready = 1'b1;
        tick();
        aw_valid = 1'b0;
        aw_ready = 1'b0;
    endtask

    task automatic b_beat(input logic [1:0] r, input logic [3:0] id);
        b_valid = 1'b1;
        b_resp  = r;
        b_id    = id;
        tick();
        b_valid = 1'b0;
        b_resp  = 2'b00;
        b_id    = 4'h0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_b_ready got %b want 0", b_ready);
        end
        checks++;
        if (cnt_out !== 32'h0 || outstanding !== 6'd0) begin
            errors++;
            $display("FAIL reset_counts got cnt=%h ost=%0d want 0 0", cnt_out, outstanding);
        end
        checks++;
        if ({err_valid, err_resp, err_id, underflow, overflow, timeout} !== 10'b0) begin
            errors++;
            $display("FAIL reset_flags got ev=%b er=%b id=%h u=%b o=%b t=%b want all 0",
                     err_valid, err_resp, err_id, underflow, overflow, timeout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (b_ready !== 1'b1 || b_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL b_ready_after_reset got %b/%b want 1", b_ready, b_ready4);
        end
    endtask

    task automatic test_counts();
        repeat (6) aw_beat();
        repeat (3) b_beat(2'b00, 4'h1);
        repeat (2) b_beat(2'b10, 4'h2);
        b_beat(2'b11, 4'h3);
        pulse_snap();
        checks++;
        if (cnt_out !== 32'h01020003) begin
            errors++;
            $display("FAIL count_mix got %h want 01020003", cnt_out);
        end
        checks++;
        if (cnt_out4 !== 16'h1203) begin
            errors++;
            $display("FAIL count_mix_w4 got %h want 1203", cnt_out4);
        end
        checks++;
        if (outstanding !== 6'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL count_mix_ost got ost=%0d u=%b want 0 0", outstanding, underflow);
        end
        pulse_clr();
    endtask

    task automatic test_saturate();
        repeat (20) aw_beat();
        repeat (20) b_beat(2'b01, 4'h0);
        pulse_snap();
        checks++;
        if (cnt_out4 !== 16'h00F0) begin
            errors++;
            $display("FAIL exokay_saturate got %h want 00f0", cnt_out4);
        end
        checks++;
        if (cnt_out !== 32'h00001400) begin
            errors++;
            $display("FAIL exokay_wide got %h want 00001400", cnt_out);
        end
        pulse_clr();
    endtask

    task automatic test_err_capture();
        repeat (2) aw_beat();
        b_beat(2'b10, 4'd5);
        checks++;
        if (err_valid !== 1'b1 || err_resp !== 2'b10 || err_id !== 4'd5) begin
            errors++;
            $display("FAIL err_first got v=%b r=%b id=%0d want 1 10 5", err_valid, err_resp, err_id);
        end
        b_beat(2'b11, 4'd9);
        checks++;
        if (err_valid !== 1'b1 || err_resp !== 2'b10 || err_id !== 4'd5) begin
            errors++;
            $display("FAIL err_hold got v=%b r=%b id=%0d want 1 10 5", err_valid, err_resp, err_id);
        end
        pulse_clr();
        checks++;
        if (err_valid !== 1'b0 || err_resp !== 2'b00 || err_id !== 4'd0) begin
            errors++;
            $display("FAIL err_clr got v=%b r=%b id=%0d want 0 00 0", err_valid, err_resp, err_id);
        end
    endtask

    task automatic test_outstanding();
        repeat (3) aw_beat();
        checks++;
        if (outstanding !== 6'd3) begin
            errors++;
            $display("FAIL ost_after_aw got %0d want 3", outstanding);
        end
        aw_valid = 1'b1;
        aw_ready = 1'b1;
        b_beat(2'b00, 4'h0);
        aw_valid = 1'b0;
        aw_ready = 1'b0;
        checks++;
        if (outstanding !== 6'd3) begin
            errors++;
            $display("FAIL ost_same_cycle got %0d want 3", outstanding);
        end
        repeat (3) b_beat(2'b00, 4'h0);
        checks++;
        if (outstanding !== 6'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL ost_drain got ost=%0d u=%b want 0 0", outstanding, underflow);
        end
        b_beat(2'b00, 4'h0);
        checks++;
        if (outstanding !== 6'd0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL ost_underflow got ost=%0d u=%b want 0 1", outstanding, underflow);
        end
        pulse_clr();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clr got %b want 0", underflow);
        end
    endtask

    task automatic test_overflow();
        repeat (63) aw_beat();
        checks++;
        if (outstanding !== 6'd63 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ost_max got ost=%0d o=%b want 63 0", outstanding, overflow);
        end
        aw_beat();
        checks++;
        if (outstanding !== 6'd63 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ost_overflow got ost=%0d o=%b want 63 1", outstanding, overflow);
        end
        repeat (63) b_beat(2'b00, 4'h0);
        pulse_clr();
        checks++;
        if (outstanding !== 6'd0 || overflow !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr got ost=%0d o=%b t=%b want 0 0 0",
                     outstanding, overflow, timeout);
        end
    endtask

    task automatic test_timeout();
        int bad;
        aw_beat();
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early got %0d early cycles want 0", bad);
        end
        tick();
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire got %b want 1", timeout);
        end
        b_beat(2'b00, 4'h0);
        pulse_clr();
        aw_beat();
        aw_beat();
        bad = 0;
        repeat (8) begin
            tick();
            if (timeout !== 1'b0) bad++;
        end
        b_beat(2'b00, 4'h0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_restart got %0d early cycles want 0", bad);
        end
        tick();
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after_restart got %b want 1", timeout);
        end
        b_beat(2'b00, 4'h0);
        pulse_clr();
    endtask

    task automatic test_clr_collision();
        aw_beat();
        clr     = 1'b1;
        b_valid = 1'b1;
        b_resp  = 2'b00;
        tick();
        clr     = 1'b0;
        b_valid = 1'b0;
        pulse_snap();
        checks++;
        if (cnt_out !== 32'h0 || cnt_out4 !== 16'h0) begin
            errors++;
            $display("FAIL clr_beats_inc got %h/%h want 0", cnt_out, cnt_out4);
        end
        checks++;
        if (outstanding !== 6'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_keeps_ost got ost=%0d u=%b want 0 0", outstanding, underflow);
        end
    endtask

    task automatic test_mid_reset();
        repeat (2) aw_beat();
        b_beat(2'b11, 4'd7);
        pulse_snap();
        rst = 1'b1;
        tick();
        checks++;
        if (cnt_out !== 32'h0 || outstanding !== 6'd0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state got cnt=%h ost=%0d rdy=%b want 0 0 0",
                     cnt_out, outstanding, b_ready);
        end
        checks++;
        if (err_valid !== 1'b0 || err_id !== 4'd0 || err_resp !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_err got v=%b r=%b id=%0d want 0 00 0",
                     err_valid, err_resp, err_id);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        aw_valid = 1'b0;
        aw_ready = 1'b0;
        b_valid  = 1'b0;
        b_resp   = 2'b00;
        b_id     = 4'h0;
        clr      = 1'b0;
        snap     = 1'b0;
        test_reset();
        test_counts();
        test_saturate();
        test_err_capture();
        test_outstanding();
        test_overflow();
        test_timeout();
        test_clr_collision();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bresp_monitor.md
# axi_bresp_monitor

Parametrised AXI write-response monitor on the B channel of the DMA/CPU write path. Counts OKAY/EXOKAY/SLVERR/DECERR responses in saturating counters, tracks outstanding writes from the AW handshake, captures the first error response with its ID, and flags response timeouts and accounting faults. A snapshot register presents all counters coherently to the register interface.

## Interface
Parameters:
- CNT_W, 8, width of each response counter
- ID_W, 4, width of AXI BID/AWID
- OST_W, 6, width of the outstanding-write counter
- TIMEOUT, 1024, cycles without a B handshake while writes are outstanding before `timeout` is set (≥2)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- aw_valid  in  1  AW channel valid (observed only)
- aw_ready  in  1  AW channel ready (observed only)
- b_valid  in  1  B channel valid
- b_resp  in  2  B channel response code
- b_id  in  ID_W  B channel ID
- b_ready  out  1  B channel ready, driven by this block
- clr  in  1  one-cycle pulse: zero counters, error capture and sticky flags
- snap  in  1  one-cycle pulse: copy live counters to snapshot
- cnt_out  out  4*CNT_W  snapshot {decerr, slverr, exokay, okay}
- outstanding  out  OST_W  live outstanding-write count
- err_valid  out  1  sticky: first SLVERR/DECERR captured
- err_resp  out  2  captured response code
- err_id  out  ID_W  captured ID
- underflow  out  1  sticky: B handshake with outstanding==0
- overflow  out  1  sticky: AW handshake with outstanding at max
- timeout  out  1  sticky: response timeout

## Operation
- AW handshake = aw_valid & aw_ready; B handshake = b_valid & b_ready.
- b_ready registered: 0 in reset, 1 from the first cycle after rst deasserts. No backpressure.
- On B handshake, counter selected by b_resp (00 okay, 01 exokay, 10 slverr, 11 decerr) increments by 1, saturating at 2^CNT_W−1.
- Outstanding: +1 on AW handshake only, −1 on B handshake only, unchanged on both. Saturates at 2^OST_W−1 (AW at max sets `overflow`). Floors at 0 (B at 0 sets `underflow`). Not affected by clr.
- Error capture: the first B handshake with b_resp[1]==1 while err_valid==0 loads err_resp/err_id and sets err_valid. Later errors do not overwrite the capture.
- Timeout: idle counter increments each cycle with outstanding≠0 and no B handshake. It zeroes on a B handshake or when outstanding==0. `timeout` sets when the counter reaches TIMEOUT; the counter then holds.
- clr zeroes the four counters, err_valid/err_resp/err_id, underflow, overflow, timeout and the idle counter. clr beats a same-cycle handshake for counters and capture, but the outstanding update still applies.
- snap copies the live counter values as they stood before this cycle's update; snapshot is not affected by clr.

## Timing
- Reset values: b_ready 0, cnt_out 0, outstanding 0, all flags 0, err_resp 0, err_id 0, snapshot 0.
- Counters, outstanding, capture and flags update on the edge ending the handshake cycle; visible next cycle.
- cnt_out reflects snap one cycle after the pulse.
- timeout visible in the cycle after the TIMEOUT-th consecutive qualifying cycle.
- rst mid-operation returns everything to reset values in one cycle. In-flight bus state is discarded.

## Structure
- Package axi_mon_pkg: RESP_OKAY/RESP_EXOKAY/RESP_SLVERR/RESP_DECERR 2-bit constants, counter index constants.
- Sub-module sat_counter (param W; inputs inc, clr; saturating), instantiated four times.

## Test plan
- Reset then 3 OKAY, 2 SLVERR, 1 DECERR, snap -> cnt_out = {8'd1, 8'd2, 8'd0, 8'd3}; b_ready = 1 from the first cycle after reset.
- CNT_W=4, 20 EXOKAY, snap -> exokay field = 15 (saturated), other fields 0.
- SLVERR id 5, then DECERR id 9 -> err_valid = 1, err_resp = 2'b10, err_id = 5; after clr all three read 0.
- 3 AW handshakes, then AW and B in the same cycle, then 3 B, then 1 extra B -> outstanding 3,3,0,0; underflow = 1.
- TIMEOUT=16, one AW, no B -> timeout = 0 after 15 cycles and 1 after 16. Repeat with a B handshake at cycle 10 -> timeout stays 0.
- clr and an OKAY handshake in the same cycle, with snap the next cycle -> okay field = 0 and outstanding decremented.
